cdb_broadcaster: RTL and testbench

- Transmitting end of the common data bus (CDB).
- Collects completed results (label + data) from the functional units / reservation stations and holds one pending result per source.
- Grants one source per cycle, round-robin, and drives the registered broadcast triple BCEN/BClabel/BCdata.
- The register file and the reservation stations consume that triple: any entry whose label matches BClabel takes BCdata and clears its label to 0.

---
 rtl/cdb_broadcaster_pkg.sv | 20 ++
 rtl/cdb_broadcaster_rr_arbiter.sv | 35 +++
 rtl/cdb_broadcaster.sv | 132 +++++++++++++
 tb/tb_cdb_broadcaster.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB constants used by the register file, reservation stations and
// the CDB broadcaster, plus the round-robin index helper.
//   CDB_LABEL_W : reservation-station label width
//   CDB_DATA_W  : result data width
//   NUM_RS      : number of reservation stations
//   NO_LABEL    : label value meaning "no producer"
package cdb_broadcaster_pkg;

   localparam int unsigned CDB_LABEL_W = 4;
   localparam int unsigned CDB_DATA_W  = 32;
   localparam int unsigned NUM_RS      = 4;
   localparam int unsigned NO_LABEL    = 0;

   // Index reached k steps after base in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned base, input int unsigned k,
                                           input int unsigned n);
      return (base + k) % n;
   endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter. Searches ptr+1, ptr+2, ... mod N and
// grants the first requester. The pointer register lives in the caller.
//   req   : request vector
//   ptr   : index of the last grant
//   grant : one-hot grant
//   idx   : encoded index of the grant
//   valid : a grant is present
module rr_arbiter
   import cdb_broadcaster_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      // k = N wraps back to ptr itself, so it gets lowest priority.
      for (int unsigned k = 1; k <= N; k++) begin
         if (!valid && req[rr_next(32'(ptr), k, N)]) begin
            valid                       = 1'b1;
            grant[rr_next(32'(ptr), k, N)] = 1'b1;
            idx                         = IW'(rr_next(32'(ptr), k, N));
         end
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmitting end of the common data bus. Holds one pending result per
// source, grants one slot per cycle round-robin and drives the registered
// broadcast triple BCEN/BClabel/BCdata.
//   clk, nRST   : clock, asynchronous active-low reset
//   flush       : squash all pending results (mispredict)
//   src_valid   : per-source result valid
//   src_label   : packed per-source labels
//   src_data    : packed per-source data
//   src_ready   : per-source slot can accept this cycle
//   BCEN        : broadcast valid
//   BClabel     : broadcast label
//   BCdata      : broadcast data
//   pending     : slot-occupied flags
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned LABEL_W = CDB_LABEL_W,
   parameter int unsigned DATA_W  = CDB_DATA_W
) (
   input  logic                       clk,
   input  logic                       nRST,
   input  logic                       flush,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*LABEL_W-1:0] src_label,
   input  logic [NUM_SRC*DATA_W-1:0]  src_data,
   output logic [NUM_SRC-1:0]         src_ready,
   output logic                       BCEN,
   output logic [LABEL_W-1:0]         BClabel,
   output logic [DATA_W-1:0]          BCdata,
   output logic [NUM_SRC-1:0]         pending
);

   localparam int unsigned IDX_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0] slot_valid_q;
   logic [LABEL_W-1:0] slot_label_q [NUM_SRC];
   logic [DATA_W-1:0]  slot_data_q  [NUM_SRC];
   logic [IDX_W-1:0]   ptr_q;
   logic               bcen_q;
   logic [LABEL_W-1:0] bclabel_q;
   logic [DATA_W-1:0]  bcdata_q;

   logic [LABEL_W-1:0] in_label [NUM_SRC];
   logic [DATA_W-1:0]  in_data  [NUM_SRC];
   logic [NUM_SRC-1:0] grant;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [NUM_SRC-1:0] load;

   rr_arbiter #(
      .N  (NUM_SRC),
      .IW (IDX_W)
   ) u_arb (
      .req   (slot_valid_q),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gnt_idx),
      .valid (gnt_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         in_label[i] = src_label[i*LABEL_W +: LABEL_W];
         in_data[i]  = src_data[i*DATA_W +: DATA_W];
      end
   end

   // A slot being broadcast this cycle can be refilled at the same edge.
   assign src_ready = {NUM_SRC{~flush}} & (~slot_valid_q | grant);
   assign load      = src_valid & src_ready;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         slot_valid_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            slot_label_q[i] <= '0;
            slot_data_q[i]  <= '0;
         end
         ptr_q     <= IDX_W'(NUM_SRC - 1);
         bcen_q    <= 1'b0;
         bclabel_q <= '0;
         bcdata_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (flush) begin
               slot_valid_q[i] <= 1'b0;
            end else if (load[i]) begin
               // Label 0 is accepted but dropped: broadcasting it would
               // overwrite every idle register.
               slot_valid_q[i] <= (in_label[i] != LABEL_W'(NO_LABEL));
               slot_label_q[i] <= in_label[i];
               slot_data_q[i]  <= in_data[i];
            end else if (grant[i]) begin
               slot_valid_q[i] <= 1'b0;
            end
         end

         if (flush) begin
            bcen_q <= 1'b0;
         end else if (gnt_any) begin
            bcen_q    <= 1'b1;
            bclabel_q <= slot_label_q[gnt_idx];
            bcdata_q  <= slot_data_q[gnt_idx];
            ptr_q     <= gnt_idx;
         end else begin
            bcen_q <= 1'b0;
         end
      end
   end

   assign BCEN    = bcen_q;
   assign BClabel = bclabel_q;
   assign BCdata  = bcdata_q;
   assign pending = slot_valid_q;

   // Two occupied slots with the same label is a producer protocol error.
   logic dup_label;
   always_comb begin
      dup_label = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int j = i + 1; j < NUM_SRC; j++) begin
            if (slot_valid_q[i] && slot_valid_q[j] && (slot_label_q[i] == slot_label_q[j])) begin
               dup_label = 1'b1;
            end
         end
      end
   end

   a_no_dup_label: assert property (@(posedge clk) disable iff (!nRST) !dup_label);

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

   localparam int unsigned NS = 4;
   localparam int unsigned LW = 4;
   localparam int unsigned DW = 32;

   logic              clk = 1'b0;
   logic              nRST;
   logic              flush;
   logic [NS-1:0]     src_valid;
   logic [NS*LW-1:0]  src_label;
   logic [NS*DW-1:0]  src_data;
   logic [NS-1:0]     src_ready;
   logic              BCEN;
   logic [LW-1:0]     BClabel;
   logic [DW-1:0]     BCdata;
   logic [NS-1:0]     pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdb_broadcaster #(
      .NUM_SRC (NS),
      .LABEL_W (LW),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .nRST      (nRST),
      .flush     (flush),
      .src_valid (src_valid),
      .src_label (src_label),
      .src_data  (src_data),
      .src_ready (src_ready),
      .BCEN      (BCEN),
      .BClabel   (BClabel),
      .BCdata    (BCdata),
      .pending   (pending)
   );

   task automatic clear_inputs();
      flush     = 1'b0;
      src_valid = '0;
      src_label = '0;
      src_data  = '0;
   endtask

   task automatic set_src(input int i, input logic v, input logic [LW-1:0] l,
                          input logic [DW-1:0] d);
      src_valid[i]          = v;
      src_label[i*LW +: LW] = l;
      src_data[i*DW +: DW]  = d;
   endtask

   // Leaves time just after a falling edge with the DUT out of reset.
   task automatic do_reset();
      @(negedge clk);
      nRST = 1'b0;
      clear_inputs();
      #2;
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      clear_inputs();
      #3;
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL reset_bcen got %0b exp 0", BCEN); end
      checks++; if (BClabel !== 4'd0) begin errors++; $display("FAIL reset_label got %0d exp 0", BClabel); end
      checks++; if (BCdata !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", BCdata); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", pending); end
      checks++; if (src_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b exp 1111", src_ready); end
      #2;
      nRST = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      set_src(0, 1'b1, 4'd3, 32'h1234_5678);
      #1;
      checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_c0 got %0b exp 1", src_ready[0]); end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL single_pending got %b exp 0001", pending); end
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL single_bcen_early got %0b exp 0", BCEN); end
      checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_c1 got %0b exp 1", src_ready[0]); end
      @(negedge clk);
      checks++; if (BCEN !== 1'b1) begin errors++; $display("FAIL single_bcen got %0b exp 1", BCEN); end
      checks++; if (BClabel !== 4'd3) begin errors++; $display("FAIL single_label got %0d exp 3", BClabel); end
      checks++; if (BCdata !== 32'h1234_5678) begin errors++; $display("FAIL single_data got %h exp 12345678", BCdata); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_after got %b exp 0000", pending); end
      @(negedge clk);
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL single_bcen_drop got %0b exp 0", BCEN); end
      checks++; if (BClabel !== 4'd3) begin errors++; $display("FAIL single_label_hold got %0d exp 3", BClabel); end
   endtask

   task automatic test_contention();
      do_reset();
      for (int round = 0; round < 2; round++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++)
            set_src(i, 1'b1, 4'(round*4 + i + 1), 32'h100 + 32'(round*4 + i));
         @(negedge clk);
         clear_inputs();
         #1;
         checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL cont_pending r%0d got %b exp 1111", round, pending); end
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (BCEN !== 1'b1 || BClabel !== 4'(round*4 + i + 1) || BCdata !== 32'h100 + 32'(round*4 + i)) begin
               errors++;
               $display("FAIL cont_order r%0d s%0d got en=%0b lbl=%0d data=%h exp en=1 lbl=%0d data=%h",
                        round, i, BCEN, BClabel, BCdata, round*4 + i + 1, 32'h100 + 32'(round*4 + i));
            end
         end
      end
      @(negedge clk);
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL cont_idle got %0b exp 0", BCEN); end
   endtask

   task automatic test_back_to_back();
      // Per-cycle source drive and expected ready[1:0] / broadcast label.
      logic       v0  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
      logic [3:0] l0  [9] = '{1, 2, 3, 3, 0, 0, 0, 0, 0};
      logic       v1  [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      logic [3:0] l1  [9] = '{5, 6, 6, 7, 7, 0, 0, 0, 0};
      logic [1:0] rdy [9] = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
      logic       en  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
      logic [3:0] lbl [9] = '{0, 0, 1, 5, 2, 6, 3, 7, 0};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         set_src(0, v0[k], l0[k], {28'h0, l0[k]});
         set_src(1, v1[k], l1[k], {28'h0, l1[k]});
         #1;
         checks++;
         if (src_ready[1:0] !== rdy[k]) begin
            errors++; $display("FAIL b2b_ready c%0d got %b exp %b", k, src_ready[1:0], rdy[k]);
         end
         checks++;
         if (BCEN !== en[k] || (en[k] && BClabel !== lbl[k])) begin
            errors++;
            $display("FAIL b2b_bcast c%0d got en=%0b lbl=%0d exp en=%0b lbl=%0d", k, BCEN, BClabel, en[k], lbl[k]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_label_zero();
      do_reset();
      @(negedge clk);
      set_src(2, 1'b1, 4'd0, 32'hDEAD);
      #1;
      checks++; if (src_ready[2] !== 1'b1) begin errors++; $display("FAIL lz_ready got %0b exp 1", src_ready[2]); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         clear_inputs();
         #1;
         checks++;
         if (pending[2] !== 1'b0 || BCEN !== 1'b0) begin
            errors++; $display("FAIL lz_idle c%0d got pend=%0b en=%0b exp pend=0 en=0", k, pending[2], BCEN);
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      @(negedge clk);
      set_src(0, 1'b1, 4'd8, 32'h8);
      set_src(2, 1'b1, 4'd9, 32'h9);
      @(negedge clk);
      clear_inputs();
      flush = 1'b1;
      set_src(1, 1'b1, 4'd10, 32'hA);
      #1;
      checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL flush_pending_pre got %b exp 0101", pending); end
      checks++; if (src_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b exp 0000", src_ready); end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL flush_pending got %b exp 0000", pending); end
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL flush_bcen got %0b exp 0", BCEN); end
      // Pointer must still favour source 0.
      set_src(0, 1'b1, 4'd1, 32'h1);
      set_src(1, 1'b1, 4'd2, 32'h2);
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL flush_no_bcast got %0b exp 0", BCEN); end
      @(negedge clk);
      checks++;
      if (BCEN !== 1'b1 || BClabel !== 4'd1) begin
         errors++; $display("FAIL flush_ptr got en=%0b lbl=%0d exp en=1 lbl=1", BCEN, BClabel);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      set_src(0, 1'b1, 4'd3, 32'h33);
      set_src(1, 1'b1, 4'd4, 32'h44);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++; if (BCEN !== 1'b1) begin errors++; $display("FAIL ar_bcen_pre got %0b exp 1", BCEN); end
      #2;
      nRST = 1'b0;
      #1;
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL ar_bcen got %0b exp 0", BCEN); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ar_pending got %b exp 0000", pending); end
      #1;
      nRST = 1'b1;
      @(negedge clk);
      set_src(0, 1'b1, 4'd5, 32'h55);
      set_src(1, 1'b1, 4'd6, 32'h66);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      checks++;
      if (BCEN !== 1'b1 || BClabel !== 4'd5 || BCdata !== 32'h55) begin
         errors++;
         $display("FAIL ar_first got en=%0b lbl=%0d data=%h exp en=1 lbl=5 data=55", BCEN, BClabel, BCdata);
      end
      @(negedge clk);
      checks++;
      if (BCEN !== 1'b1 || BClabel !== 4'd6) begin
         errors++; $display("FAIL ar_second got en=%0b lbl=%0d exp en=1 lbl=6", BCEN, BClabel);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_label_zero();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
